// File: rtl/rv_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rv_pkg;

    localparam int unsigned NREG    = 32;
    localparam int unsigned AW      = 5;
    localparam int unsigned DW      = 32;
    // Wide enough for MAX_WAIT up to 7.
    localparam int unsigned WAIT_CW = 3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaiting = 2'd1,
        StStarved = 2'd2
    } wait_state_e;

    // Writes to x0 complete the handshake but never reach the register file.
    function automatic logic is_x0(logic [AW-1:0] rd);
        return rd == '0;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of ALU, load-unit, decode and register-file signals around the arbiter.
interface rf_wb_arbiter_if
    import rv_pkg::*;
();

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [DW-1:0]   alu_data;
    logic            ld_valid;
    logic [AW-1:0]   ld_rd;
    logic [DW-1:0]   ld_data;
    logic            ld_ready;
    logic            issue_ld;
    logic [AW-1:0]   issue_rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            hazard;
    logic            alu_stall;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [DW-1:0]   rf_indata;
    logic [NREG-1:0] busy;

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  issue_ld, issue_rd, rs1, rs2,
        output ld_ready, hazard, alu_stall, rf_we, rf_rd, rf_indata, busy
    );

    // Pipeline / environment side.
    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output issue_ld, issue_rd, rs1, rs2,
        input  ld_ready, hazard, alu_stall, rf_we, rf_rd, rf_indata, busy
    );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Per-register pending-load scoreboard with read-after-write hazard detection.
module rf_scoreboard
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_rd,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [NREG-1:0] busy,
    output logic            hazard
);

    logic [NREG-1:0] busy_q, busy_d;

    // Next busy vector: clear first so a same-cycle issue to that register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en && !is_x0(set_rd)) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hazard looks at the registered vector only: no same-cycle bypass.
    always_comb begin
        hazard = (!is_x0(rs1) && busy_q[rs1]) || (!is_x0(rs2) && busy_q[rs2]);
    end

    assign busy = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU writeback and the
// load unit, with an anti-starvation wait counter that stalls the ALU.
module rf_wb_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 3
) (
    input logic            clk,
    input logic            rst,
    rf_wb_arbiter_if.slave bus
);

    localparam logic [WAIT_CW-1:0] WaitMax = WAIT_CW'(MAX_WAIT);

    logic               ld_ready;
    logic               ld_xfer;
    wait_state_e        state_q, state_d;
    logic [WAIT_CW-1:0] cnt_q, cnt_d;
    logic               alu_stall_q;
    logic               we_q, we_d;
    logic [AW-1:0]      rd_q, rd_d;
    logic [DW-1:0]      data_q, data_d;

    // Grant: ALU has priority; the load is accepted only when the ALU is idle.
    always_comb begin
        ld_ready = 1'b0;
        if (!rst && !bus.alu_valid) begin
            ld_ready = bus.ld_valid;
        end
    end

    assign ld_xfer = bus.ld_valid && ld_ready;

    // Wait FSM next state: count consecutive refusals, saturating at MAX_WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.ld_valid || ld_xfer) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            if (cnt_q != WaitMax) begin
                cnt_d = cnt_q + 1'b1;
            end
            state_d = (cnt_d == WaitMax) ? StStarved : StWaiting;
        end
    end

    // Write-port next value from whichever requester was granted.
    always_comb begin
        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (bus.alu_valid) begin
            we_d   = !is_x0(bus.alu_rd);
            rd_d   = bus.alu_rd;
            data_d = bus.alu_data;
        end else if (ld_xfer) begin
            we_d   = !is_x0(bus.ld_rd);
            rd_d   = bus.ld_rd;
            data_d = bus.ld_data;
        end
    end

    // Wait FSM, stall flag and write-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            alu_stall_q <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_stall_q <= (state_d == StStarved);
            we_q        <= we_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk    (clk),
        .rst    (rst),
        .set_en (bus.issue_ld),
        .set_rd (bus.issue_rd),
        .clr_en (ld_xfer),
        .clr_rd (bus.ld_rd),
        .rs1    (bus.rs1),
        .rs2    (bus.rs2),
        .busy   (bus.busy),
        .hazard (bus.hazard)
    );

    assign bus.ld_ready  = ld_ready;
    assign bus.alu_stall = alu_stall_q;
    assign bus.rf_we     = we_q;
    assign bus.rf_rd     = rd_q;
    assign bus.rf_indata = data_q;

    // The ALU stage must honour the stall; if it does not, it still wins the port.
    stall_honoured: assert property (@(posedge clk) disable iff (rst)
        alu_stall_q |-> !bus.alu_valid);

endmodule
